// File: rtl/hazard_scoreboard.sv
// ============================================================================
//  Module   : hazard_scoreboard
//  Purpose  : Per-register write-latency scoreboard driving ID-stage stall
//             (RAW/WAW/multiplier busy) and EX-resolved misprediction flush.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_scoreboard #(
  parameter int REG_W    = 5,
  parameter int LOAD_LAT = 1,
  parameter int MULT_LAT = 4,
  parameter int STAT_W   = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_id_valid,
  input  logic [REG_W-1:0]  i_id_rs,
  input  logic [REG_W-1:0]  i_id_rt,
  input  logic              i_id_use_rs,
  input  logic              i_id_use_rt,
  input  logic [REG_W-1:0]  i_id_rd,
  input  logic              i_id_wr_en,
  input  logic [1:0]        i_id_class,
  input  logic              i_ex_mispredict,
  output logic              o_stall,
  output logic              o_flush,
  output logic              o_mult_busy,
  output logic [STAT_W-1:0] o_stall_count
);

  localparam int c_nreg   = 2**REG_W;
  localparam int c_maxlat = (LOAD_LAT > MULT_LAT) ? LOAD_LAT : MULT_LAT;
  localparam int c_cw     = $clog2(c_maxlat + 1);

  localparam logic [c_cw-1:0]   c_load_lat = c_cw'(LOAD_LAT);
  localparam logic [c_cw-1:0]   c_mult_lat = c_cw'(MULT_LAT);
  localparam logic [c_cw-1:0]   c_one      = c_cw'(1);
  localparam logic [STAT_W-1:0] c_stat_one = STAT_W'(1);
  localparam logic [1:0]        c_cls_load = 2'b01;
  localparam logic [1:0]        c_cls_mult = 2'b10;

  logic [c_cw-1:0]   r_cnt [c_nreg];
  logic [c_cw-1:0]   r_mult_busy;
  logic [STAT_W-1:0] r_stall_count;

  logic            w_raw;
  logic            w_waw;
  logic            w_struct;
  logic            w_flush;
  logic            w_stall;
  logic            w_issue;
  logic [c_cw-1:0] w_lat;

  always_comb begin
    w_lat = '0;
    case (i_id_class)
      c_cls_load: w_lat = c_load_lat;
      c_cls_mult: w_lat = c_mult_lat;
      default:    w_lat = '0;
    endcase
  end

  // A nonzero count means the producer's result is not yet forwardable.
  always_comb begin
    w_raw    = (i_id_use_rs && (i_id_rs != '0) && (r_cnt[i_id_rs] != '0)) ||
               (i_id_use_rt && (i_id_rt != '0) && (r_cnt[i_id_rt] != '0));
    w_waw    = i_id_wr_en && (i_id_rd != '0) && (r_cnt[i_id_rd] != '0);
    w_struct = (i_id_class == c_cls_mult) && (r_mult_busy != '0);
    w_flush  = i_ex_mispredict && !i_reset;
    w_stall  = i_id_valid && (w_raw || w_waw || w_struct) && !w_flush && !i_reset;
    w_issue  = i_id_valid && !w_stall && !w_flush && !i_reset;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < c_nreg; i++) begin
        r_cnt[i] <= '0;
      end
      r_mult_busy   <= '0;
      r_stall_count <= '0;
    end else begin
      for (int i = 0; i < c_nreg; i++) begin
        if (w_issue && i_id_wr_en && (i != 0) && (i_id_rd == REG_W'(i)) && (w_lat != '0)) begin
          r_cnt[i] <= w_lat;
        end else if (r_cnt[i] != '0) begin
          r_cnt[i] <= r_cnt[i] - c_one;
        end
      end

      if (w_issue && (i_id_class == c_cls_mult)) begin
        r_mult_busy <= c_mult_lat;
      end else if (r_mult_busy != '0) begin
        r_mult_busy <= r_mult_busy - c_one;
      end

      if (w_stall && (r_stall_count != '1)) begin
        r_stall_count <= r_stall_count + c_stat_one;
      end
    end
  end

  assign o_stall       = w_stall;
  assign o_flush       = w_flush;
  assign o_mult_busy   = (r_mult_busy != '0);
  assign o_stall_count = r_stall_count;

endmodule

`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
// ============================================================================
//  Module   : tb_hazard_scoreboard
//  Purpose  : Two scoreboard instances (default and LOAD_LAT=3/MULT_LAT=2)
//             checked cycle by cycle against a ready-time reference model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [4:0] id_rs, id_rt, id_rd;
  logic       id_use_rs, id_use_rt, id_wr_en;
  logic [1:0] id_class;
  logic       ex_mispredict;

  logic        stall_a, flush_a, busy_a, stall_b, flush_b, busy_b;
  logic [15:0] cnt_a, cnt_b;

  always #5 clk = ~clk;

  hazard_scoreboard #(.REG_W(5), .LOAD_LAT(1), .MULT_LAT(4), .STAT_W(16)) dut_a (
    .i_clk(clk), .i_reset(rst), .i_id_valid(id_valid),
    .i_id_rs(id_rs), .i_id_rt(id_rt), .i_id_use_rs(id_use_rs), .i_id_use_rt(id_use_rt),
    .i_id_rd(id_rd), .i_id_wr_en(id_wr_en), .i_id_class(id_class),
    .i_ex_mispredict(ex_mispredict),
    .o_stall(stall_a), .o_flush(flush_a), .o_mult_busy(busy_a), .o_stall_count(cnt_a)
  );

  hazard_scoreboard #(.REG_W(5), .LOAD_LAT(3), .MULT_LAT(2), .STAT_W(16)) dut_b (
    .i_clk(clk), .i_reset(rst), .i_id_valid(id_valid),
    .i_id_rs(id_rs), .i_id_rt(id_rt), .i_id_use_rs(id_use_rs), .i_id_use_rt(id_use_rt),
    .i_id_rd(id_rd), .i_id_wr_en(id_wr_en), .i_id_class(id_class),
    .i_ex_mispredict(ex_mispredict),
    .o_stall(stall_b), .o_flush(flush_b), .o_mult_busy(busy_b), .o_stall_count(cnt_b)
  );

  typedef struct {
    logic [1:0] stall;
    logic       flush;
    logic [1:0] busy;
    int         cnt0;
    int         cnt1;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_err    = 0;

  // Reference model: each register holds the first cycle in which it is free.
  int c_ll[2] = '{1, 3};
  int c_ml[2] = '{4, 2};
  int rdy[2][32];
  int mfree[2];
  int sc[2];
  int t = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s at t=%0t: got %0d expected %0d", name, $time, act, expv);
    end
  endtask

  // One pipeline cycle: drive ID inputs, predict outputs, advance the model.
  task automatic step(input logic v, input logic [4:0] rs, input logic urs,
                      input logic [4:0] rt, input logic urt,
                      input logic [4:0] rd, input logic wr, input logic [1:0] cls,
                      input logic misp, input logic r, input bit chk,
                      output logic [1:0] iss);
    exp_t e;
    id_valid = v; id_rs = rs; id_use_rs = urs; id_rt = rt; id_use_rt = urt;
    id_rd = rd; id_wr_en = wr; id_class = cls; ex_mispredict = misp; rst = r;
    e.flush = misp && !r;
    e.cyc   = t;
    for (int k = 0; k < 2; k++) begin
      bit raw, waw, st, stl;
      int lat;
      raw = (urs && rs != 0 && t < rdy[k][rs]) || (urt && rt != 0 && t < rdy[k][rt]);
      waw = wr && rd != 0 && t < rdy[k][rd];
      st  = (cls == 2'b10) && t < mfree[k];
      stl = v && (raw || waw || st) && !e.flush && !r;
      e.stall[k] = stl;
      e.busy[k]  = t < mfree[k];
      if (k == 0) e.cnt0 = sc[0]; else e.cnt1 = sc[1];
      iss[k] = v && !stl && !e.flush && !r;
      if (r) begin
        for (int j = 0; j < 32; j++) rdy[k][j] = 0;
        mfree[k] = 0;
        sc[k] = 0;
      end else begin
        if (stl && sc[k] < 65535) sc[k]++;
        lat = (cls == 2'b01) ? c_ll[k] : (cls == 2'b10) ? c_ml[k] : 0;
        if (iss[k] && wr && rd != 0 && lat > 0) rdy[k][rd] = t + lat + 1;
        if (iss[k] && cls == 2'b10) mfree[k] = t + c_ml[k] + 1;
      end
    end
    if (chk) exp_q.push_back(e);
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic idle(input int n);
    logic [1:0] iss;
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1, iss);
  endtask

  task automatic do_reset();
    logic [1:0] iss;
    step(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 1, iss);
  endtask

  // Hold one instruction in ID until instance A (and B when both=1) has issued it.
  task automatic present(input logic [4:0] rs, input logic urs, input logic [4:0] rt,
                         input logic urt, input logic [4:0] rd, input logic wr,
                         input logic [1:0] cls, input bit both);
    logic [1:0] iss;
    logic [1:0] done;
    int guard;
    done = 2'b00;
    guard = 0;
    while (!(done[0] && (done[1] || !both)) && guard < 20) begin
      step(1, rs, urs, rt, urt, rd, wr, cls, 0, 0, 1, iss);
      done = done | iss;
      guard++;
    end
    if (guard >= 20) check("issue_timeout", 32'd0, 32'd1);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("stall_a", 32'(stall_a), 32'(e.stall[0]));
      check("stall_b", 32'(stall_b), 32'(e.stall[1]));
      check("flush_a", 32'(flush_a), 32'(e.flush));
      check("flush_b", 32'(flush_b), 32'(e.flush));
      check("busy_a",  32'(busy_a),  32'(e.busy[0]));
      check("busy_b",  32'(busy_b),  32'(e.busy[1]));
      check("count_a", 32'(cnt_a),   32'(e.cnt0));
      check("count_b", 32'(cnt_b),   32'(e.cnt1));
    end
  end

  initial begin
    logic [1:0] iss;
    int wait_cnt;
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 32; j++) rdy[k][j] = 0;
      mfree[k] = 0;
      sc[k] = 0;
    end
    id_valid = 0; id_rs = 0; id_rt = 0; id_rd = 0; id_use_rs = 0; id_use_rt = 0;
    id_wr_en = 0; id_class = 0; ex_mispredict = 0; rst = 1;
    step(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 0, iss);
    idle(2);

    // lw r5 ; add r6,r5,r1
    do_reset();
    present(0, 0, 0, 0, 5'd5, 1, 2'b01, 1);
    present(5'd5, 1, 5'd1, 1, 5'd6, 1, 2'b00, 1);
    idle(5);
    check("loaduse_cnt_a", 32'(cnt_a), 32'd1);
    check("loaduse_cnt_b", 32'(cnt_b), 32'd3);

    // lw r0 ; add using r0
    do_reset();
    present(0, 0, 0, 0, 5'd0, 1, 2'b01, 1);
    present(5'd0, 1, 5'd0, 1, 5'd6, 1, 2'b00, 1);
    idle(3);
    check("r0_cnt_a", 32'(cnt_a), 32'd0);
    check("r0_cnt_b", 32'(cnt_b), 32'd0);

    // mult r3 ; add using r3
    do_reset();
    present(0, 0, 0, 0, 5'd3, 1, 2'b10, 1);
    present(5'd3, 1, 0, 0, 5'd8, 1, 2'b00, 1);
    idle(6);
    check("multuse_cnt_a", 32'(cnt_a), 32'd4);
    check("multuse_cnt_b", 32'(cnt_b), 32'd2);

    // mult r3 ; mult r4 (structural)
    do_reset();
    present(5'd1, 1, 5'd2, 1, 5'd3, 1, 2'b10, 1);
    present(5'd1, 1, 5'd2, 1, 5'd4, 1, 2'b10, 0);
    idle(6);
    check("struct_cnt_a", 32'(cnt_a), 32'd4);

    // mult r3 ; ALU write r3 (WAW)
    do_reset();
    present(0, 0, 0, 0, 5'd3, 1, 2'b10, 1);
    present(0, 0, 0, 0, 5'd3, 1, 2'b00, 1);
    idle(6);
    check("waw_cnt_a", 32'(cnt_a), 32'd4);
    check("waw_cnt_b", 32'(cnt_b), 32'd2);

    // lw r5 ; flushed lw r9 reading r5 ; reader of r9 ; reader of r5
    do_reset();
    present(0, 0, 0, 0, 5'd5, 1, 2'b01, 1);
    step(1, 5'd5, 1, 0, 0, 5'd9, 1, 2'b01, 1, 0, 1, iss);
    present(5'd9, 1, 0, 0, 5'd10, 1, 2'b00, 1);
    present(5'd5, 1, 0, 0, 5'd11, 1, 2'b00, 1);
    idle(4);
    check("flush_cnt_a", 32'(cnt_a), 32'd0);
    check("flush_cnt_b", 32'(cnt_b), 32'd1);

    // mult r7 ; reset pulse ; reader of r7
    do_reset();
    present(0, 0, 0, 0, 5'd7, 1, 2'b10, 1);
    do_reset();
    check("rst_busy_a", 32'(busy_a), 32'd0);
    check("rst_busy_b", 32'(busy_b), 32'd0);
    present(5'd7, 1, 5'd7, 1, 5'd12, 1, 2'b00, 1);
    idle(2);
    check("rst_cnt_a", 32'(cnt_a), 32'd0);
    check("rst_cnt_b", 32'(cnt_b), 32'd0);

    // Randomized traffic over a small register window to provoke hazards.
    for (int i = 0; i < 600; i++) begin
      logic v, urs, urt, wr, misp, r;
      logic [4:0] rs, rt, rd;
      logic [1:0] cls;
      v    = ($urandom_range(0, 9) < 8);
      rs   = 5'($urandom_range(0, 7));
      rt   = 5'($urandom_range(0, 7));
      rd   = 5'($urandom_range(0, 7));
      urs  = 1'($urandom);
      urt  = 1'($urandom);
      wr   = 1'($urandom);
      cls  = 2'($urandom);
      misp = ($urandom_range(0, 19) == 0);
      r    = ($urandom_range(0, 63) == 0);
      step(v, rs, urs, rt, urt, rd, wr, cls, misp, r, 1, iss);
    end
    idle(2);

    wait_cnt = 0;
    while (exp_q.size() != 0 && wait_cnt < 10) begin
      @(negedge clk);
      wait_cnt++;
    end
    if (exp_q.size() != 0) check("queue_drain", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
